// File: rtl/pwm_controller_pkg.sv
// Shared types and reset defaults for the PWM sequencing controller.
// No logic here; latency and backpressure live in the modules that import it.
package pwm_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] PWM_DEF_PERIOD = 4'd15;
  localparam logic [CNT_W-1:0] PWM_DEF_DUTY   = 4'd8;
  localparam int               PWM_DEF_PRESC  = 0;

endpackage

// File: rtl/pwm_controller_if.sv
// Config handshake bundle: period/duty/prescale offered with valid, taken on valid && ready.
// Zero-latency wires; ready low means the shadow slot is still occupied.
interface pwm_controller_if #(
  parameter int PRESC_W = 8
);
  import pwm_pkg::*;

  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_period;
  logic [CNT_W-1:0]   cfg_duty;
  logic [PRESC_W-1:0] cfg_presc;

  modport master (
    output cfg_valid, cfg_period, cfg_duty, cfg_presc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_duty, cfg_presc,
    output cfg_ready
  );

endinterface

// File: rtl/pwm_controller_nbitcomparator.sv
// Unsigned N-bit magnitude comparator: Ab = a>b, ab = a==b, aB = a<b.
// Purely combinational, no backpressure.
module nbitcomparator #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         Ab,
  output logic         ab,
  output logic         aB
);

  assign Ab = (a > b);
  assign ab = (a == b);
  assign aB = (a < b);

endmodule

// File: rtl/pwm_controller.sv
// Prescaled 4-bit PWM sequencer; pwm_out/period_end lag the counter by one clock.
// Config is double-buffered: one shadow slot, cfg_ready low until it commits at a period boundary.
module pwm_controller
  import pwm_pkg::*;
#(
  parameter int                 PRESC_W    = 8,
  parameter logic [CNT_W-1:0]   DEF_PERIOD = PWM_DEF_PERIOD,
  parameter logic [CNT_W-1:0]   DEF_DUTY   = PWM_DEF_DUTY,
  parameter logic [PRESC_W-1:0] DEF_PRESC  = PRESC_W'(PWM_DEF_PRESC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  pwm_controller_if.slave         cfg,
  output logic                    pwm_out,
  output logic                    period_end,
  output logic                    busy
);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_act_q, period_act_d;
  logic [CNT_W-1:0]   duty_act_q, duty_act_d;
  logic [PRESC_W-1:0] presc_act_q, presc_act_d;
  logic [CNT_W-1:0]   shd_period_q, shd_period_d;
  logic [CNT_W-1:0]   shd_duty_q, shd_duty_d;
  logic [PRESC_W-1:0] shd_presc_q, shd_presc_d;
  logic               pending_q, pending_d;
  logic               pwm_out_q, pwm_out_d;
  logic               period_end_q, period_end_d;

  logic run, tick, wrap, accept, commit;
  logic cmp_lt, cmp_gt_unused, cmp_eq_unused;

  nbitcomparator #(.N(CNT_W)) u_cmp (
    .a  (cnt_q),
    .b  (duty_act_q),
    .Ab (cmp_gt_unused),
    .ab (cmp_eq_unused),
    .aB (cmp_lt)
  );

  always_comb begin
    run    = (state_q == RUN) && en;
    tick   = run && (pc_q == presc_act_q);
    wrap   = tick && (cnt_q == period_act_q);
    accept = cfg.cfg_valid && !pending_q;
    // pending_q is still 0 on an accept-at-wrap cycle, so that wrap cannot commit it
    commit = pending_q && ((state_q == IDLE) || wrap);

    state_d = en ? RUN : IDLE;

    pc_d = pc_q;
    if (!run || tick) pc_d = '0;
    else              pc_d = pc_q + 1'b1;

    cnt_d = cnt_q;
    if (!run || wrap) cnt_d = '0;
    else if (tick)    cnt_d = cnt_q + 1'b1;

    shd_period_d = shd_period_q;
    shd_duty_d   = shd_duty_q;
    shd_presc_d  = shd_presc_q;
    if (accept) begin
      shd_period_d = cfg.cfg_period;
      shd_duty_d   = cfg.cfg_duty;
      shd_presc_d  = cfg.cfg_presc;
    end

    pending_d = pending_q;
    if (accept)      pending_d = 1'b1;
    else if (commit) pending_d = 1'b0;

    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;
    presc_act_d  = presc_act_q;
    if (commit) begin
      period_act_d = shd_period_q;
      duty_act_d   = shd_duty_q;
      presc_act_d  = shd_presc_q;
    end

    pwm_out_d    = run && cmp_lt;
    period_end_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      cnt_q        <= '0;
      period_act_q <= DEF_PERIOD;
      duty_act_q   <= DEF_DUTY;
      presc_act_q  <= DEF_PRESC;
      shd_period_q <= '0;
      shd_duty_q   <= '0;
      shd_presc_q  <= '0;
      pending_q    <= 1'b0;
      pwm_out_q    <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      duty_act_q   <= duty_act_d;
      presc_act_q  <= presc_act_d;
      shd_period_q <= shd_period_d;
      shd_duty_q   <= shd_duty_d;
      shd_presc_q  <= shd_presc_d;
      pending_q    <= pending_d;
      pwm_out_q    <= pwm_out_d;
      period_end_q <= period_end_d;
    end
  end

  assign cfg.cfg_ready = !pending_q;
  assign pwm_out       = pwm_out_q;
  assign period_end    = period_end_q;
  assign busy          = (state_q == RUN);

endmodule
